cdc_hs_rx_ctrl: RTL

Receive-side controller for a toggle-based req/ack bus-synchronizer channel. It runs entirely in the destination clock domain and consumes the request toggle after it has passed through the 2-FF synchronizer. It detects each new request, waits a settle window, captures the quasi-static source bus and presents it on a valid/ready interface. When the consumer accepts the word, it flips an ack toggle that returns to the source domain through another 2-FF synchronizer.

---
 rtl/cdc_hs_rx_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cdc_hs_rx_ctrl.sv
`default_nettype none
// cdc_hs_rx_ctrl: destination-side req/ack toggle handshake controller (settle, capture, valid/ready, ack toggle).
// Optional sticky overrun detection enabled by defining OVERRUN_DET_EN.  Rev 1.0
module cdc_hs_rx_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic                  req_sync,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  data_ready,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  ack_toggle,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETTLE = 2'b01,
    HOLD   = 2'b10
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  req_q, req_q_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic                  valid_nx;
  logic                  ack_nx;
  logic                  req_edge;

  assign req_edge = (req_sync != req_q);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      ack_toggle <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      req_q      <= req_q_nx;
      data_out   <= data_nx;
      data_valid <= valid_nx;
      ack_toggle <= ack_nx;
      busy       <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req_q_nx = req_q;
    data_nx  = data_out;
    valid_nx = data_valid;
    ack_nx   = ack_toggle;
    case (state)
      IDLE: begin
        if (req_edge) begin
          req_q_nx = req_sync;
          if (SETTLE_CYCLES == 0) begin
            data_nx  = bus_in;
            valid_nx = 1'b1;
            state_nx = HOLD;
          end else begin
            cnt_nx   = SETTLE_INIT;
            state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        cnt_nx = cnt - 4'd1;
        // Capture on the last settle cycle; <= also guards a corrupted zero count.
        if (cnt <= 4'd1) begin
          data_nx  = bus_in;
          valid_nx = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (data_valid && data_ready) begin
          valid_nx = 1'b0;
          ack_nx   = ~ack_toggle;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef OVERRUN_DET_EN
  logic overrun_nx;

  // A fresh toggle while a word is still in flight means the source ran ahead of ack.
  always_comb begin
    overrun_nx = overrun;
    if (((state == SETTLE) || (state == HOLD)) && req_edge)
      overrun_nx = 1'b1;
    else if (err_clr)
      overrun_nx = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) overrun <= 1'b0;
    else        overrun <= overrun_nx;
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overrun        = 1'b0;
`endif

endmodule
`default_nettype wire
